// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit controller with architectural HI/LO.
// Revision 1.0 -- initial release.
`default_nettype none

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mdu_A,
  input  logic [31:0] mdu_B,
  input  logic [3:0]  MDUCtrl,
  input  logic        start,
  output logic        busy,
  output logic [31:0] mdu_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [63:0]      pend;
  logic             pend_we;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // One shared unsigned divider; signed div works on magnitudes and fixes signs
  // afterwards, which also yields 0x80000000 for the -2^31 / -1 overflow case.
  always_comb begin
    prod_s  = $signed({{32{mdu_A[31]}}, mdu_A}) * $signed({{32{mdu_B[31]}}, mdu_B});
    prod_u  = {32'b0, mdu_A} * {32'b0, mdu_B};
    a_neg   = (MDUCtrl == OP_DIV) && mdu_A[31];
    b_neg   = (MDUCtrl == OP_DIV) && mdu_B[31];
    a_mag   = a_neg ? (32'd0 - mdu_A) : mdu_A;
    b_mag   = b_neg ? (32'd0 - mdu_B) : mdu_B;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    case (MDUCtrl)
      OP_MFHI: mdu_out = HI;
      OP_MFLO: mdu_out = LO;
      default: mdu_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      pend    <= 64'd0;
      pend_we <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (MDUCtrl)
              OP_MULT, OP_MULTU: begin
                pend    <= (MDUCtrl == OP_MULT) ? prod_s : prod_u;
                pend_we <= 1'b1;
                count   <= MULT_LOAD;
                busy    <= 1'b1;
                state   <= BUSY;
              end
              OP_DIV, OP_DIVU: begin
                pend    <= {rem, quot};
                pend_we <= (mdu_B != 32'd0);
                count   <= DIV_LOAD;
                busy    <= 1'b1;
                state   <= BUSY;
              end
              OP_MTHI: HI <= mdu_A;
              OP_MTLO: LO <= mdu_A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (count == CNT_ONE) begin
            if (pend_we) begin
              HI <= pend[63:32];
              LO <= pend[31:0];
            end
            pend_we <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard-based bench for mdu_ctrl.
// Revision 1.0 -- initial release.
`default_nettype none

module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] mdu_A;
  logic [31:0] mdu_B;
  logic [3:0]  MDUCtrl;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [63:0] exp_q[$];
  int          len_q[$];

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .mdu_A(mdu_A), .mdu_B(mdu_B), .MDUCtrl(MDUCtrl),
    .start(start), .busy(busy), .mdu_out(mdu_out), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {h, l};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expectation, then drive a one-cycle start; returns at the first busy sample.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(op, a, b, hi_m, lo_m));
    len_q.push_back((op <= 4'd2) ? MULT_N : DIV_N);
    mdu_A   = a;
    mdu_B   = b;
    MDUCtrl = op;
    start   = 1'b1;
    step();
    start   = 1'b0;
    MDUCtrl = 4'd0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      step();
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mdu_A = 32'h1111_2222; mdu_B = 32'h3; MDUCtrl = 4'd1; start = 1'b1;
    step();
    start = 1'b0; MDUCtrl = 4'd0;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", LO); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored got=%b want=0", busy); end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_arith();
    logic [3:0]  ops[10];
    logic [31:0] as[10];
    logic [31:0] bs[10];
    logic [63:0] e;
    int          n, c;
    ops[0] = 4'd1; as[0] = 32'hFFFF_FFFE; bs[0] = 32'd3;
    ops[1] = 4'd2; as[1] = 32'hFFFF_FFFE; bs[1] = 32'd3;
    ops[2] = 4'd3; as[2] = 32'hFFFF_FFF9; bs[2] = 32'd2;
    ops[3] = 4'd4; as[3] = 32'd7;         bs[3] = 32'd2;
    ops[4] = 4'd3; as[4] = 32'h8000_0000; bs[4] = 32'hFFFF_FFFF;
    ops[5] = 4'd3; as[5] = 32'd100;       bs[5] = 32'hFFFF_FFF9;
    for (int i = 6; i < 10; i++) begin
      ops[i] = 4'($urandom_range(1, 4));
      as[i]  = $urandom;
      bs[i]  = (ops[i] >= 4'd3) ? 32'($urandom_range(1, 5000)) : $urandom;
    end
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arith%0d_busy_start got=%b want=1", i, busy); end
      checks++; if (HI !== hi_m) begin errors++; $display("FAIL arith%0d_early_hi got=%h want=%h", i, HI, hi_m); end
      wait_idle(c);
      e = exp_q.pop_front();
      n = len_q.pop_front();
      checks++; if (c != n) begin errors++; $display("FAIL arith%0d_busy_len got=%0d want=%0d", i, c, n); end
      checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL arith%0d_hilo op=%0d got=%h want=%h", i, ops[i], {HI, LO}, e); end
      MDUCtrl = 4'd6; #1;
      checks++; if (mdu_out !== e[31:0]) begin errors++; $display("FAIL arith%0d_mflo got=%h want=%h", i, mdu_out, e[31:0]); end
      MDUCtrl = 4'd0;
      hi_m = e[63:32]; lo_m = e[31:0];
    end
  endtask

  task automatic test_mthi_divzero();
    logic [63:0] e;
    int          c;
    mdu_A = 32'h1234_5678; MDUCtrl = 4'd7; start = 1'b1;
    step();
    start = 1'b0; MDUCtrl = 4'd5; #1;
    checks++; if (mdu_out !== 32'h1234_5678) begin errors++; $display("FAIL mthi_mfhi got=%h want=12345678", mdu_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b want=0", busy); end
    hi_m = 32'h1234_5678;
    mdu_A = 32'hCAFE_0001; MDUCtrl = 4'd8; start = 1'b1;
    step();
    start = 1'b0; MDUCtrl = 4'd0;
    checks++; if (LO !== 32'hCAFE_0001 || HI !== hi_m) begin errors++; $display("FAIL mtlo got=%h_%h want=%h_cafe0001", HI, LO, hi_m); end
    lo_m = 32'hCAFE_0001;
    issue(4'd3, 32'd55, 32'd0);
    wait_idle(c);
    e = exp_q.pop_front();
    void'(len_q.pop_front());
    checks++; if (c != DIV_N) begin errors++; $display("FAIL divzero_len got=%0d want=%0d", c, DIV_N); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL divzero_hilo got=%h want=%h", {HI, LO}, e); end
  endtask

  task automatic test_noop();
    logic [3:0] codes[10];
    codes[0] = 4'd0; codes[1] = 4'd5; codes[2] = 4'd6;
    for (int i = 3; i < 10; i++) codes[i] = 4'(i + 6);
    for (int i = 0; i < 10; i++) begin
      mdu_A = $urandom; mdu_B = $urandom; MDUCtrl = codes[i]; start = 1'b1;
      #1;
      if (codes[i] != 4'd5 && codes[i] != 4'd6) begin
        checks++; if (mdu_out !== 32'd0) begin errors++; $display("FAIL noop_out code=%0d got=%h want=0", codes[i], mdu_out); end
      end
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
        errors++; $display("FAIL noop code=%0d got=%b_%h_%h want=0_%h_%h", codes[i], busy, HI, LO, hi_m, lo_m);
      end
    end
    MDUCtrl = 4'd0;
  endtask

  task automatic test_ignore_busy();
    logic [63:0] e;
    int          c;
    issue(4'd1, 32'h0000_1234, 32'h0000_0100);
    step();
    mdu_A = 32'hDEAD_BEEF; mdu_B = 32'd9; MDUCtrl = 4'd8; start = 1'b1;
    step();
    MDUCtrl = 4'd3; mdu_B = 32'd1;
    step();
    start = 1'b0; MDUCtrl = 4'd0;
    wait_idle(c);
    e = exp_q.pop_front();
    void'(len_q.pop_front());
    checks++; if (c + 3 != MULT_N) begin errors++; $display("FAIL ignore_len got=%0d want=%0d", c + 3, MULT_N); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL ignore_hilo got=%h want=%h", {HI, LO}, e); end
    hi_m = e[63:32]; lo_m = e[31:0];
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    int          c;
    issue(4'd3, 32'hFFFF_FF00, 32'd3);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(exp_q.pop_front()); void'(len_q.pop_front());
    hi_m = 32'd0; lo_m = 32'd0;
    checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL resetmid got=%b_%h_%h want=0_0_0", busy, HI, LO); end
    repeat (15) step();
    checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL resetmid_late got=%b_%h_%h want=0_0_0", busy, HI, LO); end
    // Reset landing on the completion edge must win over the write-back.
    issue(4'd2, 32'h0000_0777, 32'h0000_0555);
    repeat (MULT_N - 1) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(exp_q.pop_front()); void'(len_q.pop_front());
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL reset_vs_done got=%h_%h want=0_0", HI, LO); end
    issue(4'd1, 32'hFFFF_FFF0, 32'd5);
    wait_idle(c);
    e = exp_q.pop_front();
    void'(len_q.pop_front());
    checks++; if (c != MULT_N || {HI, LO} !== e) begin errors++; $display("FAIL after_reset got=%0d_%h want=%0d_%h", c, {HI, LO}, MULT_N, e); end
    hi_m = e[63:32]; lo_m = e[31:0];
  endtask

  task automatic test_back_to_back();
    logic [63:0] e_div, e_mul;
    int          c;
    logic        held;
    issue(4'd4, 32'd100, 32'd7);
    wait_idle(c);
    e_div = exp_q.pop_front();
    void'(len_q.pop_front());
    checks++; if (c != DIV_N || {HI, LO} !== e_div) begin errors++; $display("FAIL b2b_div got=%0d_%h want=%0d_%h", c, {HI, LO}, DIV_N, e_div); end
    hi_m = e_div[63:32]; lo_m = e_div[31:0];
    issue(4'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    held = 1'b1;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      if ({HI, LO} !== e_div) held = 1'b0;
      step();
      c++;
    end
    e_mul = exp_q.pop_front();
    void'(len_q.pop_front());
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold got=0 want=1"); end
    checks++; if (c != MULT_N) begin errors++; $display("FAIL b2b_len got=%0d want=%0d", c, MULT_N); end
    checks++; if ({HI, LO} !== e_mul) begin errors++; $display("FAIL b2b_mult got=%h want=%h", {HI, LO}, e_mul); end
    hi_m = e_mul[63:32]; lo_m = e_mul[31:0];
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDUCtrl = 4'd0; mdu_A = 32'd0; mdu_B = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    step();
    test_reset();
    test_arith();
    test_mthi_divzero();
    test_noop();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
